// File: rtl/xif_copro_pkg.sv
// xif_copro_pkg: shared types for the XIF coprocessor controller.
// Copro instruction encoding: custom-0 opcode (7'b0001011), funct7 = 0,
// funct3[2] = 0, funct3[1:0] selects the operation. FLUSH writes no rd.
package xif_copro_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    EXEC        = 2'd2,
    RESULT      = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    OP_BITREV = 2'd0,
    OP_POPCNT = 2'd1,
    OP_CLZ    = 2'd2,
    OP_FLUSH  = 2'd3
  } copro_op_e;

  typedef struct packed {
    logic      use_copro;
    logic      rd_write;
    copro_op_e op;
    logic [4:0] rd;
  } decoder_t;

endpackage

// File: rtl/xif_copro_decoder.sv
// xif_copro_decoder: purely combinational decode of an offloaded instruction.
module xif_copro_decoder
  import xif_copro_pkg::*;
(
  input  logic [31:0] instr_i,
  output decoder_t    dec_o
);

  // Source-register fields are irrelevant here; operands arrive on rs1 port.
  logic unused_fields;
  assign unused_fields = ^instr_i[24:15];

  // Classify the instruction and extract op / rd / writeback requirement.
  always_comb begin
    dec_o           = '0;
    dec_o.op        = copro_op_e'(instr_i[13:12]);
    dec_o.rd        = instr_i[11:7];
    dec_o.use_copro = (instr_i[6:0] == OPC_CUSTOM0) &&
                      (instr_i[31:25] == 7'd0) && !instr_i[14];
    dec_o.rd_write  = dec_o.use_copro && (dec_o.op != OP_FLUSH);
  end

endmodule

// File: rtl/xif_copro_ctrl.sv
// xif_copro_ctrl: issue/commit/exec/result sequencer for one in-flight
// XIF coprocessor instruction. Optional perf counters: XIF_COPRO_CTRL_PERF_EN.
module xif_copro_ctrl
  import xif_copro_pkg::*;
#(
  parameter int ID_W         = 4,
  parameter int EXEC_TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [31:0]     issue_rs1_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            exec_start_o,
  output copro_op_e       exec_op_o,
  output logic [31:0]     exec_operand_o,
  input  logic            exec_done_i,
  input  logic [31:0]     exec_result_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [31:0]     result_data_o,
  output logic            result_we_o,
  output logic            busy_o
`ifdef XIF_COPRO_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_done_o,
  output logic [31:0]     perf_kill_o
`endif
);

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

  ctrl_state_e     state_q, state_d;
  decoder_t        dec;
  logic [ID_W-1:0] id_q;
  logic [4:0]      rd_q;
  copro_op_e       op_q;
  logic [31:0]     operand_q;
  logic            wb_q;
  logic [31:0]     result_q;
  logic            result_we_q;
  logic            start_q;
  logic [CNT_W-1:0] cnt_q;

  logic issue_hs;
  logic commit_match;
  logic timeout_hit;
  logic result_hs;
  logic kill_hs;
  logic in_result;

  xif_copro_decoder u_decoder (
    .instr_i (issue_instr_i),
    .dec_o   (dec)
  );

  assign issue_ready_o  = rst_ni && (state_q == IDLE);
  assign issue_hs       = issue_valid_i && issue_ready_o;
  assign issue_accept_o    = issue_hs && dec.use_copro;
  assign issue_writeback_o = issue_hs && dec.rd_write;

  assign commit_match = commit_valid_i && (commit_id_i == id_q);
  assign timeout_hit  = (cnt_q == CNT_W'(EXEC_TIMEOUT - 1));
  assign result_hs    = (state_q == RESULT) && result_ready_i;
  assign kill_hs      = (state_q == WAIT_COMMIT) && commit_match && commit_kill_i;
  assign in_result    = (state_q == RESULT);

  assign busy_o         = (state_q != IDLE);
  assign exec_start_o   = start_q;
  assign exec_op_o      = op_q;
  assign exec_operand_o = operand_q;
  assign result_valid_o = in_result;
  assign result_id_o    = in_result ? id_q        : '0;
  assign result_rd_o    = in_result ? rd_q        : '0;
  assign result_data_o  = in_result ? result_q    : '0;
  assign result_we_o    = in_result && result_we_q;

  // Next-state logic; commits seen while still IDLE are deliberately ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (issue_hs && dec.use_copro) state_d = WAIT_COMMIT;
      WAIT_COMMIT: if (commit_match) state_d = commit_kill_i ? IDLE : EXEC;
      EXEC:        if (exec_done_i || timeout_hit) state_d = RESULT;
      RESULT:      if (result_ready_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // State, instruction context, exec start pulse, timeout counter and result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rd_q        <= '0;
      op_q        <= OP_BITREV;
      operand_q   <= '0;
      wb_q        <= 1'b0;
      result_q    <= '0;
      result_we_q <= 1'b0;
      start_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (issue_hs && dec.use_copro) begin
        id_q      <= issue_id_i;
        rd_q      <= dec.rd;
        op_q      <= dec.op;
        operand_q <= issue_rs1_i;
        wb_q      <= dec.rd_write;
      end
      start_q <= (state_q == WAIT_COMMIT) && commit_match && !commit_kill_i;
      if (state_q == EXEC) begin
        if (cnt_q != CNT_W'(EXEC_TIMEOUT)) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if ((state_q == EXEC) && exec_done_i) begin
        result_q    <= exec_result_i;
        result_we_q <= wb_q;
      end else if ((state_q == EXEC) && timeout_hit) begin
        result_q    <= '0;
        result_we_q <= 1'b0;
      end
    end
  end

`ifdef XIF_COPRO_CTRL_PERF_EN
  logic [31:0] perf_done_q;
  logic [31:0] perf_kill_q;

  assign perf_done_o = perf_done_q;
  assign perf_kill_o = perf_kill_q;

  // Wrapping counters of retired results and killed instructions.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_done_q <= '0;
      perf_kill_q <= '0;
    end else begin
      if (result_hs) perf_done_q <= perf_done_q + 32'd1;
      if (kill_hs)   perf_kill_q <= perf_kill_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xif_copro_ctrl.sv
// tb_xif_copro_ctrl: self-checking bench for xif_copro_ctrl.
module tb_xif_copro_ctrl;
  import xif_copro_pkg::*;

  localparam int ID_W         = 4;
  localparam int EXEC_TIMEOUT = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            issue_valid_i = 1'b0;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i = '0;
  logic [ID_W-1:0] issue_id_i = '0;
  logic [31:0]     issue_rs1_i = '0;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            commit_valid_i = 1'b0;
  logic [ID_W-1:0] commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            exec_start_o;
  copro_op_e       exec_op_o;
  logic [31:0]     exec_operand_o;
  logic            exec_done_i = 1'b0;
  logic [31:0]     exec_result_i = '0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [ID_W-1:0] result_id_o;
  logic [4:0]      result_rd_o;
  logic [31:0]     result_data_o;
  logic            result_we_o;
  logic            busy_o;
`ifdef XIF_COPRO_CTRL_PERF_EN
  logic [31:0]     perf_done_o;
  logic [31:0]     perf_kill_o;
  logic [31:0]     exp_perf_done = '0;
  logic [31:0]     exp_perf_kill = '0;
`endif

  int errors = 0;
  int checks = 0;

  xif_copro_ctrl #(.ID_W(ID_W), .EXEC_TIMEOUT(EXEC_TIMEOUT)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .exec_start_o      (exec_start_o),
    .exec_op_o         (exec_op_o),
    .exec_operand_o    (exec_operand_o),
    .exec_done_i       (exec_done_i),
    .exec_result_i     (exec_result_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_rd_o       (result_rd_o),
    .result_data_o     (result_data_o),
    .result_we_o       (result_we_o),
    .busy_o            (busy_o)
`ifdef XIF_COPRO_CTRL_PERF_EN
    ,
    .perf_done_o       (perf_done_o),
    .perf_kill_o       (perf_kill_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and land 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Behavioural model of the instruction set the controller recognises.
  function automatic bit model_copro(input logic [31:0] instr);
    return (instr[6:0] == 7'h0B) && (instr[31:25] == 7'h00) && (instr[14:12] < 3'd4);
  endfunction

  function automatic bit model_writes(input logic [31:0] instr);
    return model_copro(instr) && (instr[14:12] != 3'd3);
  endfunction

  // Behavioural executor used to produce plausible exec results.
  function automatic logic [31:0] model_exec(input logic [1:0] op, input logic [31:0] a);
    logic [31:0] r;
    int n;
    r = '0;
    n = 0;
    case (op)
      2'd0: for (int i = 0; i < 32; i++) r[31-i] = a[i];
      2'd1: begin for (int i = 0; i < 32; i++) n += int'(a[i]); r = 32'(n); end
      2'd2: begin
        n = 32;
        for (int i = 0; i < 32; i++) if (a[i]) n = 31 - i;
        r = 32'(n);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] make_instr(input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] w;
    w = $urandom;
    w[31:25] = 7'h00;
    w[14:12] = f3;
    w[11:7]  = rd;
    w[6:0]   = 7'h0B;
    return w;
  endfunction

  // One complete transaction: issue, optional early/wrong commits, exec, result.
  // done_delay < 0 means exec_done_i is never raised.
  task automatic run_txn(input logic [31:0] instr, input logic [ID_W-1:0] id,
                         input logic [31:0] rs1, input bit kill, input bit early_commit,
                         input bit wrong_commit, input int done_delay,
                         input int ready_delay, input logic [31:0] exec_val,
                         input int exp_latency);
    bit exp_acc, exp_wb, done_used, got;
    int wait_cycles, exec_cycles, exp_exec, cyc, lat;
    logic [31:0] exp_data;
    exp_acc = model_copro(instr);
    exp_wb  = model_writes(instr);
    wait_cycles = wrong_commit ? 2 : 1;

    issue_valid_i = 1'b1; issue_instr_i = instr; issue_id_i = id; issue_rs1_i = rs1;
    if (early_commit) begin
      commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = 1'b1;
    end
    #2;
    checks++;
    if (issue_ready_o !== 1'b1 || issue_accept_o !== exp_acc || issue_writeback_o !== exp_wb) begin
      errors++;
      $display("FAIL issue_resp: ready/acc/wb got %b%b%b want 1%b%b",
               issue_ready_o, issue_accept_o, issue_writeback_o, exp_acc, exp_wb);
    end
    step();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0; cyc = 1;
    #2;
    if (!exp_acc) begin
      checks++;
      if (busy_o !== 1'b0 || issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL non_copro_idle: busy/ready/rvalid got %b%b%b want 010",
                 busy_o, issue_ready_o, result_valid_o);
      end
      return;
    end
    checks++;
    if (busy_o !== 1'b1 || issue_ready_o !== 1'b0 || exec_start_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_commit: busy/ready/start got %b%b%b want 100",
               busy_o, issue_ready_o, exec_start_o);
    end
    if (wrong_commit) begin
      commit_valid_i = 1'b1; commit_id_i = id ^ 4'h1; commit_kill_i = 1'($urandom);
      step(); cyc++;
      commit_valid_i = 1'b0;
      #2;
      checks++;
      if (busy_o !== 1'b1 || exec_start_o !== 1'b0 || issue_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL wrong_id_commit: busy/start/ready got %b%b%b want 100",
                 busy_o, exec_start_o, issue_ready_o);
      end
    end
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    step(); cyc++;
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    if (kill) begin
      #2;
      checks++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL kill_idle: busy/rvalid/ready got %b%b%b want 001",
                 busy_o, result_valid_o, issue_ready_o);
      end
`ifdef XIF_COPRO_CTRL_PERF_EN
      exp_perf_kill++;
      checks++;
      if (perf_kill_o !== exp_perf_kill) begin
        errors++;
        $display("FAIL perf_kill: got %0d want %0d", perf_kill_o, exp_perf_kill);
      end
`endif
      return;
    end
    done_used = (done_delay >= 0) && (done_delay < EXEC_TIMEOUT);
    exp_exec  = done_used ? done_delay + 1 : EXEC_TIMEOUT;
    exp_data  = done_used ? exec_val : 32'h0;
    got = 1'b0; exec_cycles = 0; lat = 0;
    for (int c = 0; c < EXEC_TIMEOUT + 8; c++) begin
      if (c == done_delay) begin exec_done_i = 1'b1; exec_result_i = exec_val; end
      #2;
      checks++;
      if (exec_start_o !== (c == 0) || exec_op_o !== copro_op_e'(instr[13:12]) ||
          exec_operand_o !== rs1 || result_valid_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL exec_cycle%0d: start=%b op=%0d opnd=%h rvalid=%b want start=%b op=%0d opnd=%h rvalid=0",
                 c, exec_start_o, exec_op_o, exec_operand_o, result_valid_o,
                 (c == 0), instr[13:12], rs1);
      end
      step(); cyc++;
      exec_done_i = 1'b0; exec_result_i = $urandom;
      if (result_valid_o === 1'b1) begin got = 1'b1; exec_cycles = c + 1; lat = cyc + 1; break; end
    end
    checks++;
    if (!got || exec_cycles != exp_exec) begin
      errors++;
      $display("FAIL exec_length: got %0d cycles (seen=%b) want %0d", exec_cycles, got, exp_exec);
    end
    checks++;
    if (lat != 1 + wait_cycles + exp_exec + 1 || (exp_latency > 0 && lat != exp_latency)) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", lat, 1 + wait_cycles + exp_exec + 1);
    end
    if (!got) return;
    for (int r = 0; r <= ready_delay; r++) begin
      result_ready_i = (r == ready_delay);
      #2;
      checks++;
      if (result_valid_o !== 1'b1 || result_id_o !== id || result_rd_o !== instr[11:7] ||
          result_data_o !== exp_data || result_we_o !== (done_used && exp_wb) ||
          issue_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL result_hold%0d: v=%b id=%0d rd=%0d data=%h we=%b rdy=%b want 1 %0d %0d %h %b 0",
                 r, result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
                 issue_ready_o, id, instr[11:7], exp_data, (done_used && exp_wb));
      end
      step();
    end
    result_ready_i = 1'b0;
    #2;
    checks++;
    if (busy_o !== 1'b0 || issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL result_release: busy/ready/rvalid got %b%b%b want 010",
               busy_o, issue_ready_o, result_valid_o);
    end
`ifdef XIF_COPRO_CTRL_PERF_EN
    exp_perf_done++;
    checks++;
    if (perf_done_o !== exp_perf_done) begin
      errors++;
      $display("FAIL perf_done: got %0d want %0d", perf_done_o, exp_perf_done);
    end
`endif
  endtask

  // Outputs while reset is held, then ready right after release.
  task automatic test_reset();
    rst_ni = 1'b0;
    step(); step();
    #2;
    checks++;
    if ({issue_ready_o, issue_accept_o, issue_writeback_o, exec_start_o, result_valid_o,
         result_we_o, busy_o} !== 7'b0 || exec_operand_o !== 32'h0 || result_data_o !== 32'h0 ||
        result_id_o !== '0 || result_rd_o !== 5'h0 || exec_op_o !== OP_BITREV) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b rvalid=%b opnd=%h want all 0",
               issue_ready_o, busy_o, result_valid_o, exec_operand_o);
    end
    step();
    rst_ni = 1'b1;
    #2;
    checks++;
    if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready/busy got %b%b want 10", issue_ready_o, busy_o);
    end
    step();
  endtask

  // BITREV of 1 with the fastest commit/done timing.
  task automatic test_bitrev();
    run_txn(make_instr(3'd0, 5'd7), 4'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
            0, 0, 32'h8000_0000, 4);
  endtask

  task automatic test_non_copro();
    run_txn(32'h0000_0013, 4'd2, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 0);
  endtask

  // Same-cycle commit ignored, wrong-id commit ignored, matching kill honoured.
  task automatic test_kill();
    run_txn(make_instr(3'd1, 5'd9), 4'd5, 32'hF0F0_0001, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_txn(make_instr(3'd2, 5'd4), 4'd6, 32'h0000_0100, 1'b0, 1'b0, 1'b0,
            -1, 0, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_backpressure();
    run_txn(make_instr(3'd1, 5'd31), 4'd10, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1,
            2, 10, model_exec(2'd1, 32'hFFFF_0000), 0);
  endtask

  // Reset asserted mid-EXEC; a late done must not produce a result.
  task automatic test_reset_exec();
    issue_valid_i = 1'b1; issue_instr_i = make_instr(3'd0, 5'd3); issue_id_i = 4'd7;
    issue_rs1_i = 32'hAAAA_5555;
    step();
    issue_valid_i = 1'b0; commit_valid_i = 1'b1; commit_id_i = 4'd7; commit_kill_i = 1'b0;
    step();
    commit_valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    step();
    #2;
    checks++;
    if ({issue_ready_o, exec_start_o, result_valid_o, result_we_o, busy_o} !== 5'b0 ||
        exec_operand_o !== 32'h0 || result_id_o !== '0 || result_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_exec: ready=%b busy=%b opnd=%h want 0 0 0",
               issue_ready_o, busy_o, exec_operand_o);
    end
    step();
    rst_ni = 1'b1; exec_done_i = 1'b1; exec_result_i = 32'h1111_2222;
    step();
    exec_done_i = 1'b0;
    #2;
    checks++;
    if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL late_done_ignored: busy/rvalid/ready got %b%b%b want 001",
               busy_o, result_valid_o, issue_ready_o);
    end
`ifdef XIF_COPRO_CTRL_PERF_EN
    exp_perf_done = '0; exp_perf_kill = '0;
    checks++;
    if (perf_done_o !== 32'h0 || perf_kill_o !== 32'h0) begin
      errors++;
      $display("FAIL perf_reset: done=%0d kill=%0d want 0 0", perf_done_o, perf_kill_o);
    end
`endif
    step();
  endtask

  // Randomised back-to-back transactions against the behavioural model.
  task automatic test_random();
    logic [31:0] instr, rs1;
    int dd;
    for (int n = 0; n < 24; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        instr[6:0]   = 7'h0B;
        instr[31:25] = ($urandom_range(0, 7) == 0) ? 7'h01 : 7'h00;
      end
      rs1 = $urandom;
      dd  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn(instr, 4'($urandom), rs1, ($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom), dd, int'($urandom_range(0, 3)),
              model_exec(instr[13:12], rs1), 0);
    end
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_non_copro();
    test_kill();
    test_timeout();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xif_copro_ctrl.md
XIF_COPRO_CTRL -- requirements
Module: xif_copro_ctrl

Interface
REQ-001 SHALL have parameter ID_W, default 4, meaning the XIF instruction-id width.
REQ-002 SHALL have parameter EXEC_TIMEOUT, default 64, meaning the maximum cycles allowed in EXEC before an abort.
REQ-003 SHALL have port clk_i, input, 1, clock; the block uses one clock, and reset is synchronous and active-low.
REQ-004 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have issue ports: issue_valid_i in 1; issue_ready_o out 1; issue_instr_i in 32; issue_id_i in ID_W; issue_rs1_i in 32.
REQ-006 SHALL have issue response ports: issue_accept_o out 1 (instruction is a copro op); issue_writeback_o out 1 (will write rd).
REQ-007 SHALL have commit ports: commit_valid_i in 1; commit_id_i in ID_W; commit_kill_i in 1.
REQ-008 SHALL have exec ports: exec_start_o out 1; exec_op_o out copro_op_e; exec_operand_o out 32; exec_done_i in 1; exec_result_i in 32.
REQ-009 SHALL have result ports: result_valid_o out 1; result_ready_i in 1; result_id_o out ID_W; result_rd_o out 5; result_data_o out 32; result_we_o out 1.
REQ-010 SHALL have busy_o, out, 1, high whenever state != IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_COMMIT, EXEC, RESULT.
REQ-012 SHALL drive issue_ready_o = 1 only in IDLE; an issue handshake is issue_valid_i && issue_ready_o.
REQ-013 SHALL decode issue_instr_i combinationally; in the handshake cycle, issue_accept_o = use_copro and issue_writeback_o = use_copro && rd-write required; both are 0 outside the handshake cycle.
REQ-014 SHALL, on a handshake with use_copro = 0, stay in IDLE and latch nothing.
REQ-015 SHALL, on an accepted handshake, latch id, rd (instr[11:7]), op and rs1, then go to WAIT_COMMIT the next cycle.
REQ-016 SHALL treat commit_valid_i as relevant only when commit_id_i equals the latched id; non-matching commits are ignored.
REQ-017 SHALL, in WAIT_COMMIT on a matching commit with kill = 0, go to EXEC; with kill = 1, go to IDLE with no result.
REQ-018 SHALL, when a matching commit arrives in the same cycle as the issue handshake, not consume it; the commit is honoured only from WAIT_COMMIT onward.
REQ-019 SHALL pulse exec_start_o for exactly one cycle, the first EXEC cycle, with exec_op_o and exec_operand_o stable throughout EXEC.
REQ-020 SHALL, on exec_done_i in EXEC, latch exec_result_i and go to RESULT; exec_done_i outside EXEC is ignored.
REQ-021 SHALL count EXEC cycles in a saturating counter of width $clog2(EXEC_TIMEOUT+1); on reaching EXEC_TIMEOUT without done, go to RESULT with result_data_o = 0 and result_we_o = 0.
REQ-022 SHALL hold result_valid_o = 1 in RESULT with all result fields stable until result_ready_i; on the handshake it SHALL return to IDLE.
REQ-023 SHALL give minimum latency of 4 cycles from issue handshake to result_valid_o, with commit the cycle after issue and exec_done_i on the first EXEC cycle.

Reset
REQ-024 SHALL, on a rst_ni low at a clock edge, enter IDLE from any state (including mid-EXEC) and clear the latched id, rd, op, operand, result and timeout counter to 0.
REQ-025 SHALL drive all outputs to 0 during reset except issue_ready_o, which is 0 while rst_ni = 0 and 1 the first cycle after release.

Configuration
REQ-026 SHALL, with XIF_COPRO_CTRL_PERF_EN defined, add output ports perf_done_o (32) and perf_kill_o (32), wrapping counters of completed results and killed instructions, cleared by reset.
REQ-027 SHALL, without XIF_COPRO_CTRL_PERF_EN, omit those ports and counters entirely.

Structure
REQ-028 SHALL place ctrl_state_e, copro_op_e and decoder_t in xif_copro_pkg.
REQ-029 SHALL instantiate exactly one sub-module, xif_copro_decoder, fed by issue_instr_i.

Verification
REQ-030 Bench SHALL cover: BITREV issue id=3 rs1=0x00000001, commit id=3 kill=0, done next cycle with result 0x80000000 -> result_valid with id=3, data=0x80000000, we=1, 4-cycle latency.
REQ-031 Bench SHALL cover: non-copro instr 0x00000013 issued -> accept=0, state stays IDLE, issue_ready_o stays 1.
REQ-032 Bench SHALL cover: accepted id=5, commit id=4 then id=5 kill=1 -> id=4 ignored, return to IDLE, no result_valid_o; perf_kill_o increments by 1 when XIF_COPRO_CTRL_PERF_EN is defined.
REQ-033 Bench SHALL cover: exec_done_i never asserted, EXEC_TIMEOUT=64 -> result_valid_o 64 cycles after entering EXEC, data=0, we=0.
REQ-034 Bench SHALL cover: result_ready_i held 0 for 10 cycles -> result fields stable and issue_ready_o=0 throughout; on ready=1, IDLE next cycle.
REQ-035 Bench SHALL cover: rst_ni low during EXEC -> IDLE, all outputs 0, a later exec_done_i ignored.
